fetch_unit: RTL and testbench

- Consumer and driver of the program counter in the 8-bit core.
- Reads the PC value and fetches opcode (plus an optional operand byte) from instruction memory over a req/ack handshake.
- Pulses pc_enable to advance the PC and pc_ld/pc_inp to redirect it on jumps.
- Presents decoded-ready instructions to the decoder over a valid/ready handshake.

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/fetch_mem_if.sv | 54 +++++
 rtl/fetch_unit.sv | 141 ++++++++++++++
 tb/tb_fetch_unit.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit core: bus widths, special opcodes and the
// fetch sequencer state encoding.
package cpu_pkg;

  localparam int ADDR_W      = 8;
  localparam int DATA_W      = 8;
  localparam int TIMEOUT_CYC = 15;

  localparam logic [7:0] JMP_OP = 8'hA0;
  localparam logic [7:0] HLT_OP = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH_OP,
    ST_INC_OP,
    ST_FETCH_OPR,
    ST_INC_OPR,
    ST_JUMP,
    ST_DISPATCH,
    ST_HALT
  } fetch_state_t;

endpackage

// File: rtl/fetch_mem_if.sv
// Single-outstanding req/ack read port shared by opcode and operand fetches.
// With FETCH_TIMEOUT_EN defined, a stalled request raises a one-cycle timeout.
module fetch_mem_if
  import cpu_pkg::*;
#(
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int DATA_W = cpu_pkg::DATA_W
`ifdef FETCH_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = cpu_pkg::TIMEOUT_CYC
`endif
) (
`ifdef FETCH_TIMEOUT_EN
  input  logic              clk,
  input  logic              reset,
`endif
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              mem_ack,
  output logic              done,
  output logic [DATA_W-1:0] rd_data,
  output logic              timeout
);

  // An ack only counts while a request is up; stray acks are ignored.
  assign mem_rd   = req;
  assign mem_addr = req ? addr : '0;
  assign done     = req && mem_ack;
  assign rd_data  = mem_data;

`ifdef FETCH_TIMEOUT_EN
  localparam int                CNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] wait_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      wait_cnt <= '0;
    else if (!req || mem_ack)
      wait_cnt <= '0;
    else
      wait_cnt <= wait_cnt + CNT_W'(1);
  end

  // Fires on the last cycle of the window, so mem_rd is high for exactly TIMEOUT_CYC cycles.
  assign timeout = req && !mem_ack && (wait_cnt == CNT_LAST);
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: reads opcode/operand bytes at the PC, steps or
// reloads the PC, and hands instructions to the decoder. Optional: FETCH_TIMEOUT_EN.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int               ADDR_W = cpu_pkg::ADDR_W,
  parameter int               DATA_W = cpu_pkg::DATA_W,
  parameter logic [DATA_W-1:0] JMP_OP = cpu_pkg::JMP_OP,
  parameter logic [DATA_W-1:0] HLT_OP = cpu_pkg::HLT_OP
`ifdef FETCH_TIMEOUT_EN
  , parameter int             TIMEOUT_CYC = cpu_pkg::TIMEOUT_CYC
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_addr,
  output logic              pc_enable,
  output logic              pc_ld,
  output logic [ADDR_W-1:0] pc_inp,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              mem_ack,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic [DATA_W-1:0] ir_opcode,
  output logic [DATA_W-1:0] ir_operand,
  output logic              halted,
  output logic              fetch_err
);

  fetch_state_t      state, next_state;
  logic [DATA_W-1:0] opcode_q, operand_q;
  logic              fetch_req, done, timeout;
  logic [DATA_W-1:0] rd_data;

  assign fetch_req = (state == ST_FETCH_OP) || (state == ST_FETCH_OPR);

  fetch_mem_if #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
`ifdef FETCH_TIMEOUT_EN
    , .TIMEOUT_CYC(TIMEOUT_CYC)
`endif
  ) u_mem_if (
`ifdef FETCH_TIMEOUT_EN
    .clk     (clk),
    .reset   (reset),
`endif
    .req     (fetch_req),
    .addr    (pc_addr),
    .mem_rd  (mem_rd),
    .mem_addr(mem_addr),
    .mem_data(mem_data),
    .mem_ack (mem_ack),
    .done    (done),
    .rd_data (rd_data),
    .timeout (timeout)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= ST_IDLE;
    else
      state <= next_state;
  end

  // A new opcode clears the operand so single-byte instructions present 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      opcode_q  <= '0;
      operand_q <= '0;
    end else if (done) begin
      if (state == ST_FETCH_OP) begin
        opcode_q  <= rd_data;
        operand_q <= '0;
      end else begin
        operand_q <= rd_data;
      end
    end
  end

  always_comb begin
    next_state = state;
    pc_enable  = 1'b0;
    pc_ld      = 1'b0;
    ir_valid   = 1'b0;
    halted     = 1'b0;
    case (state)
      ST_IDLE:      next_state = ST_FETCH_OP;
      ST_FETCH_OP: begin
        if (timeout)   next_state = ST_HALT;
        else if (done) next_state = ST_INC_OP;
      end
      ST_INC_OP: begin
        pc_enable = 1'b1;
        if (opcode_q == HLT_OP)      next_state = ST_HALT;
        else if (opcode_q[DATA_W-1]) next_state = ST_FETCH_OPR;
        else                         next_state = ST_DISPATCH;
      end
      ST_FETCH_OPR: begin
        if (timeout)   next_state = ST_HALT;
        else if (done) next_state = ST_INC_OPR;
      end
      ST_INC_OPR: begin
        pc_enable  = 1'b1;
        next_state = (opcode_q == JMP_OP) ? ST_JUMP : ST_DISPATCH;
      end
      ST_JUMP: begin
        pc_ld      = 1'b1;
        next_state = ST_FETCH_OP;
      end
      ST_DISPATCH: begin
        ir_valid = 1'b1;
        if (ir_ready) next_state = ST_FETCH_OP;
      end
      ST_HALT:      halted = 1'b1;
      default:      next_state = ST_IDLE;
    endcase
  end

  assign pc_inp     = pc_ld ? operand_q[ADDR_W-1:0] : '0;
  assign ir_opcode  = opcode_q;
  assign ir_operand = operand_q;

`ifdef FETCH_TIMEOUT_EN
  logic err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      err_q <= 1'b0;
    else if (timeout)
      err_q <= 1'b1;
  end

  assign fetch_err = err_q;
`else
  assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: PC and memory models around the DUT, an instruction-level
// reference model filling a scoreboard, and a monitor that checks each dispatch.
module tb_fetch_unit;

  localparam int SIG_RD    = 0;
  localparam int SIG_VALID = 1;
  localparam int SIG_LD    = 2;
  localparam int SIG_HALT  = 3;
  localparam int SIG_NOVAL = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] pc_addr;
  logic       pc_enable, pc_ld;
  logic [7:0] pc_inp;
  logic       mem_rd;
  logic [7:0] mem_addr, mem_data;
  logic       mem_ack;
  logic       ir_valid, ir_ready;
  logic [7:0] ir_opcode, ir_operand;
  logic       halted, fetch_err;

  fetch_unit dut (
    .clk       (clk),
    .reset     (reset),
    .pc_addr   (pc_addr),
    .pc_enable (pc_enable),
    .pc_ld     (pc_ld),
    .pc_inp    (pc_inp),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_ack   (mem_ack),
    .ir_valid  (ir_valid),
    .ir_ready  (ir_ready),
    .ir_opcode (ir_opcode),
    .ir_operand(ir_operand),
    .halted    (halted),
    .fetch_err (fetch_err)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  logic [7:0]  mem [256];
  logic [15:0] exp_q[$];
  logic [15:0] model_q[$];
  bit          force_ack = 0, no_ack = 0, rand_mem = 0, rand_ready = 0;
  int          rand_wait = 0, wait_cnt = 0, req_wait, stall = 0;
  int          pc_en_count = 0, pc_ld_count = 0, dispatch_count = 0, rd_in_reset = 0;
  logic        prev_valid = 0, prev_ready = 0, prev_rd = 0, prev_ack = 0, prev_en = 0, prev_ld = 0;
  logic [7:0]  prev_op, prev_opr, prev_addr;

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  // The program counter the fetch unit drives and reads back.
  always @(posedge clk or negedge reset) begin
    if (!reset)         pc_addr <= 8'h00;
    else if (pc_ld)     pc_addr <= pc_inp;
    else if (pc_enable) pc_addr <= pc_addr + 8'd1;
  end

  always @* begin
    req_wait = rand_mem ? rand_wait : ((mem_addr == 8'h18) ? 3 : 0);
    mem_ack  = force_ack || (!no_ack && mem_rd && (wait_cnt >= req_wait));
    mem_data = mem[mem_addr];
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) wait_cnt <= 0;
    else if (mem_rd && mem_ack) begin
      wait_cnt  <= 0;
      rand_wait <= $urandom_range(0, 3);
    end else if (mem_rd) wait_cnt <= wait_cnt + 1;
  end

  initial begin
    ir_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) ir_ready = ($urandom_range(0, 2) != 0);
      else if (ir_valid && ir_opcode == 8'h85 && stall < 4) begin
        ir_ready = 1'b0;
        stall++;
      end else ir_ready = 1'b1;
    end
  end

  // Monitor: protocol rules every cycle, scoreboard pop on each transfer.
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_rd) rd_in_reset++;
      prev_valid = 0; prev_rd = 0; prev_en = 0; prev_ld = 0;
    end else begin
      if (pc_enable || pc_ld) check_output("pulse_exclusive", {63'd0, pc_enable && pc_ld}, 64'd0);
      if (pc_enable) begin pc_en_count++; check_output("pc_enable_single", {63'd0, prev_en}, 64'd0); end
      if (pc_ld)     begin pc_ld_count++; check_output("pc_ld_single", {63'd0, prev_ld}, 64'd0); end
      if (prev_valid && !prev_ready) begin
        check_output("ir_valid_held", {63'd0, ir_valid}, 64'd1);
        check_output("ir_data_stable", {48'd0, ir_opcode, ir_operand}, {48'd0, prev_op, prev_opr});
      end
      if (prev_rd && !prev_ack && !no_ack) begin
        check_output("mem_rd_held", {63'd0, mem_rd}, 64'd1);
        check_output("mem_addr_stable", {56'd0, mem_addr}, {56'd0, prev_addr});
      end
      if (mem_rd) check_output("mem_addr_is_pc", {56'd0, mem_addr}, {56'd0, pc_addr});
      if (halted) check_output("halt_quiet", {61'd0, mem_rd, pc_enable, pc_ld}, 64'd0);
      if (ir_valid && ir_ready) begin
        dispatch_count++;
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("[TB] FAIL unexpected_dispatch: actual=%0h_%0h required=none", ir_opcode, ir_operand);
        end else
          check_output("dispatch", {48'd0, ir_opcode, ir_operand}, {48'd0, exp_q.pop_front()});
      end
      prev_valid = ir_valid; prev_ready = ir_ready; prev_op = ir_opcode; prev_opr = ir_operand;
      prev_rd = mem_rd; prev_ack = mem_ack; prev_addr = mem_addr; prev_en = pc_enable; prev_ld = pc_ld;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic bit sig_sel(input int sel);
    case (sel)
      SIG_RD:    return mem_rd;
      SIG_VALID: return ir_valid;
      SIG_LD:    return pc_ld;
      SIG_HALT:  return halted;
      SIG_NOVAL: return !ir_valid;
      default:   return 1'b0;
    endcase
  endfunction

  task automatic wait_sig(input string name, input int sel, input int limit, output int n);
    n = 0;
    while (!sig_sel(sel) && n < limit) begin tick(); n++; end
    tests++;
    if (!sig_sel(sel)) begin
      fails++;
      $display("[TB] FAIL %s: actual=not seen in %0d cycles required=seen", name, limit);
    end
  endtask

  // Asserted reset with a spurious ack pending; outputs must clear asynchronously.
  task automatic apply_reset();
    exp_q.delete();
    stall = 0;
    force_ack = 1'b1;
    reset = 1'b0;
    #1;
    check_output("reset_async_drop", {62'd0, mem_rd, ir_valid}, 64'd0);
    rd_in_reset = 0;
    repeat (2) tick();
    check_output("reset_pulses", {54'd0, pc_enable, pc_ld, pc_inp}, 64'd0);
    check_output("reset_mem", {55'd0, mem_rd, mem_addr}, 64'd0);
    check_output("reset_ir", {47'd0, ir_valid, ir_opcode, ir_operand}, 64'd0);
    check_output("reset_status", {62'd0, halted, fetch_err}, 64'd0);
    check_output("reset_no_rd", rd_in_reset, 0);
    pc_en_count = 0; pc_ld_count = 0; dispatch_count = 0;
    force_ack = 1'b0;
    reset = 1'b1;
  endtask

  // Instruction-level reference: walk the program from address 0.
  function automatic bit run_model(output bit halts);
    logic [7:0] pc, op, opr;
    int disp;
    model_q.delete();
    halts = 0; pc = 8'h00; disp = 0;
    for (int steps = 0; steps < 400; steps++) begin
      op = mem[pc]; pc = pc + 8'd1;
      if (op == 8'hFF) begin halts = 1; return 1'b1; end
      opr = 8'h00;
      if (op[7]) begin opr = mem[pc]; pc = pc + 8'd1; end
      if (op == 8'hA0) pc = opr;
      else begin
        model_q.push_back({op, opr});
        disp++;
        if (disp == 30) return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic fill_random();
    for (int i = 0; i < 256; i++) begin
      int r;
      r = $urandom_range(0, 63);
      mem[i] = (r == 0) ? 8'hFF : (r < 5) ? 8'hA0 : 8'($urandom);
    end
  endtask

  int n;
  bit ok, halts;
  int tries;

  initial begin
    reset = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h12; mem[8'h01] = 8'h85; mem[8'h02] = 8'h3C;
    mem[8'h03] = 8'hA0; mem[8'h04] = 8'hFF; mem[8'hFF] = 8'hA0; mem[8'h18] = 8'hFF;

    apply_reset();
    exp_q.push_back(16'h1200);
    exp_q.push_back(16'h853C);
    wait_sig("first_rd", SIG_RD, 10, n);
    check_output("first_rd_cycle", n, 1);
    check_output("first_rd_addr", {56'd0, mem_addr}, 64'h00);
    wait_sig("single_valid", SIG_VALID, 10, n);
    check_output("single_latency", n, 2);
    check_output("single_pc_pulses", pc_en_count, 1);
    wait_sig("single_done", SIG_NOVAL, 10, n);
    wait_sig("second_rd", SIG_RD, 10, n);
    check_output("second_addr", {56'd0, mem_addr}, 64'h01);
    wait_sig("two_byte_valid", SIG_VALID, 20, n);
    check_output("two_byte_pc_pulses", pc_en_count, 3);
    wait_sig("two_byte_done", SIG_NOVAL, 20, n);
    wait_sig("third_rd", SIG_RD, 10, n);
    check_output("third_addr", {56'd0, mem_addr}, 64'h03);
    mem[8'h00] = 8'h18;
    wait_sig("jump_ff", SIG_LD, 20, n);
    check_output("jump_ff_target", {56'd0, pc_inp}, 64'hFF);
    tick();
    wait_sig("jump_wrap", SIG_LD, 20, n);
    check_output("jump_wrap_target", {56'd0, pc_inp}, 64'h18);
    wait_sig("after_jump_rd", SIG_RD, 3, n);
    check_output("after_jump_addr", {56'd0, mem_addr}, 64'h18);
    wait_sig("halt", SIG_HALT, 20, n);
    repeat (10) tick();
    check_output("halt_state", {62'd0, halted, mem_rd}, 64'b10);
    check_output("halt_pc_pulses", pc_en_count, 8);
    check_output("jump_pc_loads", pc_ld_count, 2);
    check_output("directed_dispatches", dispatch_count, 2);
    check_output("directed_drained", exp_q.size(), 0);

    apply_reset();
    wait_sig("refetch_rd", SIG_RD, 10, n);
    check_output("refetch_addr", {56'd0, mem_addr}, 64'h00);

    for (int r = 0; r < 4; r++) begin
      ok = 0; tries = 0;
      while (!ok && tries < 20) begin fill_random(); ok = run_model(halts); tries++; end
      if (!ok) begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        ok = run_model(halts);
      end
      rand_mem = 1; rand_ready = 1;
      apply_reset();
      exp_q = model_q;
      if (halts) begin
        wait_sig("rand_halt", SIG_HALT, 4000, n);
        repeat (3) tick();
      end else begin
        n = 0;
        while (exp_q.size() != 0 && n < 4000) begin tick(); n++; end
      end
      check_output("rand_drained", exp_q.size(), 0);
      check_output("rand_halted", {63'd0, halted}, {63'd0, halts});
    end

`ifdef FETCH_TIMEOUT_EN
    rand_mem = 0; rand_ready = 0; no_ack = 1;
    apply_reset();
    wait_sig("timeout_rd", SIG_RD, 10, n);
    n = 0;
    while (mem_rd && n < 40) begin tick(); n++; end
    check_output("timeout_rd_cycles", n, 15);
    check_output("timeout_status", {61'd0, mem_rd, fetch_err, halted}, 64'b011);
    repeat (3) tick();
    check_output("timeout_sticky", {62'd0, fetch_err, halted}, 64'b11);
`else
    check_output("fetch_err_tied", {63'd0, fetch_err}, 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
